// File: rtl/rom_arb_pkg.sv
// Shared types and default sizing for the boot ROM port arbiter and the ROM wrapper.
package rom_arb_pkg;

  localparam int unsigned ROM_AW_DEF       = 12;
  localparam int unsigned READ_LATENCY_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-winner pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt_c
);

  // 1 when requester 1 won the most recent grant; reset so requester 0 wins the first tie
  logic r_last_1;

  always_comb begin
    o_gnt_c = 2'b00;
    case (i_req)
      2'b01:   o_gnt_c = 2'b01;
      2'b10:   o_gnt_c = 2'b10;
      2'b11:   o_gnt_c = r_last_1 ? 2'b01 : 2'b10;
      default: o_gnt_c = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_1 <= 1'b1;
    end else if (|o_gnt_c) begin
      r_last_1 <= o_gnt_c[1];
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the single-port boot ROM between instruction fetch and the load/store read path,
// one transaction at a time, with range/alignment checking and valid/ready responses.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ROM_AW       = ROM_AW_DEF,
  parameter logic [63:0] BASE_ADDR    = 64'h0,
  parameter int unsigned READ_LATENCY = READ_LATENCY_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [63:0]       if_addr,
  output logic              if_gnt,
  input  logic              if_flush,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_data,
  output logic              if_rsp_err,
  input  logic              if_rsp_ready,
  input  logic              ls_req,
  input  logic [63:0]       ls_addr,
  output logic              ls_gnt,
  output logic              ls_rsp_valid,
  output logic [31:0]       ls_rsp_data,
  output logic              ls_rsp_err,
  input  logic              ls_rsp_ready,
  output logic              rom_ce,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data
);

  localparam int unsigned CNT_W     = $clog2(READ_LATENCY + 1);
  localparam logic [63:0] ROM_BYTES = 64'd4 << ROM_AW;

  state_e              r_state;
  owner_e              r_owner;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_if_rsp_valid;
  logic                r_ls_rsp_valid;
  logic [31:0]         r_rsp_data;
  logic                r_rsp_err;
  logic                r_rom_ce;
  logic [ROM_AW-1:0]   r_rom_addr;

  logic [1:0]          w_req;
  logic [1:0]          w_gnt;
  logic                w_accept;
  logic [63:0]         w_addr;
  logic [63:0]         w_off;
  logic                w_err;
  logic                w_rsp_ready;
  logic                w_flush_own;

  // Requests are only arbitrated in IDLE; a flush masks the IF request
  assign w_req = (r_state == ST_IDLE) ? {ls_req, if_req & ~if_flush} : 2'b00;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (w_req),
    .o_gnt_c (w_gnt)
  );

  assign if_gnt   = w_gnt[0];
  assign ls_gnt   = w_gnt[1];
  assign w_accept = |w_gnt;

  assign w_addr = w_gnt[1] ? ls_addr : if_addr;
  assign w_off  = w_addr - BASE_ADDR;
  assign w_err  = (w_addr[1:0] != 2'b00) || (w_addr < BASE_ADDR) || (w_off >= ROM_BYTES);

  assign w_rsp_ready = (r_owner == OWN_IF) ? if_rsp_ready : ls_rsp_ready;
  assign w_flush_own = if_flush && (r_owner == OWN_IF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_owner        <= OWN_IF;
      r_cnt          <= '0;
      r_if_rsp_valid <= 1'b0;
      r_ls_rsp_valid <= 1'b0;
      r_rsp_data     <= 32'h0;
      r_rsp_err      <= 1'b0;
      r_rom_ce       <= 1'b0;
      r_rom_addr     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_owner <= w_gnt[1] ? OWN_LS : OWN_IF;
            if (w_err) begin
              r_state        <= ST_RESP;
              r_rsp_data     <= 32'h0;
              r_rsp_err      <= 1'b1;
              r_if_rsp_valid <= w_gnt[0];
              r_ls_rsp_valid <= w_gnt[1];
            end else begin
              r_state    <= ST_ACCESS;
              r_rom_ce   <= 1'b1;
              r_rom_addr <= w_off[ROM_AW+1:2];
              r_cnt      <= CNT_W'(READ_LATENCY);
            end
          end
        end
        ST_ACCESS: begin
          if (w_flush_own) begin
            r_state  <= ST_IDLE;
            r_rom_ce <= 1'b0;
          end else if (r_cnt == CNT_W'(1)) begin
            r_state        <= ST_RESP;
            r_rom_ce       <= 1'b0;
            r_rsp_data     <= rom_data;
            r_rsp_err      <= 1'b0;
            r_if_rsp_valid <= (r_owner == OWN_IF);
            r_ls_rsp_valid <= (r_owner == OWN_LS);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          // A handshake and a flush in the same cycle both end in IDLE with valid low
          if (w_rsp_ready || w_flush_own) begin
            r_state        <= ST_IDLE;
            r_if_rsp_valid <= 1'b0;
            r_ls_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign if_rsp_valid = r_if_rsp_valid;
  assign ls_rsp_valid = r_ls_rsp_valid;
  assign if_rsp_data  = r_rsp_data;
  assign ls_rsp_data  = r_rsp_data;
  assign if_rsp_err   = r_rsp_err;
  assign ls_rsp_err   = r_rsp_err;
  assign rom_ce       = r_rom_ce;
  assign rom_addr     = r_rom_addr;

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single-port boot ROM block RAM between two requesters: instruction fetch (IF) and load/store read path (LS).
- Arbitrates between them round-robin and sequences the ROM's fixed read latency.
- Returns each response through a valid/ready handshake; out-of-range and misaligned addresses get an error response.
- Sits between the core's fetch/LSU front ends and the boot ROM memory macro.

Parameters:
- ROM_AW, 12: ROM word-address width (ROM holds 2^ROM_AW 32-bit words).
- BASE_ADDR, 64'h0: byte address of ROM word 0.
- READ_LATENCY, 2: clock cycles from the first cycle rom_ce is high to valid rom_data (minimum 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  IF read request; held with if_addr until if_gnt.
- if_addr  in  64  IF byte address.
- if_gnt  out  1  IF request accepted this cycle.
- if_flush  in  1  discard any IF transaction in flight.
- if_rsp_valid  out  1  IF response valid.
- if_rsp_data  out  32  IF response word.
- if_rsp_err  out  1  IF response error.
- if_rsp_ready  in  1  IF accepts the response.
- ls_req, ls_addr, ls_gnt, ls_rsp_valid, ls_rsp_data, ls_rsp_err, ls_rsp_ready: same widths and meaning for the LS port (LS has no flush).
- rom_ce  out  1  ROM enable.
- rom_addr  out  ROM_AW  ROM word address.
- rom_data  in  32  ROM read data.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State IDLE.
  - All gnt, rsp_valid and rsp_err outputs 0; rsp_data 0.
  - rom_ce 0; rom_addr 0.
  - Round-robin pointer set so IF wins the first tie.
  - Reset mid-transaction abandons it; no response is ever produced for it.
- One transaction in flight at a time. States: IDLE, ACCESS, RESP.
- IDLE:
  - gnt is combinational from req and the rr pointer.
  - Only one requester asserting: it wins.
  - Both asserting: the one not granted last time wins.
  - At most one gnt high per cycle. req&gnt = accept.
  - On accept, latch owner and address, and update the rr pointer.
  - off = addr - BASE_ADDR, computed 64-bit unsigned.
  - Error case (addr[1:0]!=0, or addr<BASE_ADDR, or off>=4*2^ROM_AW): go to RESP with data 0, err 1. rom_ce stays 0.
  - Otherwise: go to ACCESS with rom_addr=off[ROM_AW+1:2] and the latency counter loaded with READ_LATENCY.
- ACCESS:
  - rom_ce=1 and rom_addr stable for exactly READ_LATENCY cycles.
  - In the last ACCESS cycle, capture rom_data into the response register with err=0, then go to RESP.
  - rom_ce returns to 0 in RESP.
- RESP:
  - Owner's rsp_valid=1; data and err held stable until the owner's rsp_ready.
  - Handshake: next cycle IDLE, rsp_valid=0.
  - No new grant is issued in the handshake cycle, so back-to-back throughput is one transaction per READ_LATENCY+2 cycles.
  - The non-owner's rsp_valid is always 0.
- Latency: accept in cycle T gives rsp_valid in cycle T+1+READ_LATENCY (valid read) or T+1 (error).
- if_flush:
  - Owner IF in ACCESS or RESP: return to IDLE next cycle; rom_ce 0 and if_rsp_valid 0 from that cycle; data discarded.
  - Flush in the same cycle as an IF response handshake: the handshake completes normally.
  - if_flush high in IDLE: if_gnt forced 0, so LS may be granted that cycle.
  - Owner LS: flush has no effect.
- A requester that drops req before gnt is legal; nothing is latched.
- All state updates on posedge clk; counter width is clog2(READ_LATENCY+1).

Decomposition:
- Shared package rom_arb_pkg:
  - state encoding enum (IDLE/ACCESS/RESP);
  - owner encoding (OWN_IF=0, OWN_LS=1);
  - default ROM_AW and READ_LATENCY constants, shared with the ROM wrapper.
- One natural sub-module: rr_arb2, a two-way round-robin arbiter with a priority pointer (combinational grant plus registered last-grant). All else stays in rom_port_arbiter.

Test Plan:
- Single IF read, addr=BASE_ADDR+0x10, READ_LATENCY=2, rom returns 32'h00000013 at word 4 -> rom_addr=4; rom_ce high 2 cycles; if_rsp_valid at T+3 with data 32'h00000013, err 0.
- if_req and ls_req both high continuously, all rsp_ready=1 -> grants alternate IF, LS, IF, LS; each transaction completes before the next grant; no cycle with both gnt high.
- ls_addr=BASE_ADDR+0x4002 (misaligned) and then BASE_ADDR+(1<<14) (out of range, ROM_AW=12) -> ls_rsp_valid at T+1, err=1, data 0, rom_ce never asserted.
- IF response presented with if_rsp_ready=0 for 5 cycles, ls_req high -> if_rsp_data stable all 5 cycles, ls_gnt=0 throughout; ls_gnt in the cycle after the IF handshake.
- if_flush asserted in the second ACCESS cycle -> next cycle IDLE, rom_ce 0, if_rsp_valid never asserted; a pending ls_req is then granted.
- rst_n pulsed low during RESP of an LS transaction -> all outputs 0 immediately (asynchronous); after release, a simultaneous IF/LS request grants IF first.
